// File: rtl/fp64_pkg.sv
// Shared constants and FSM state type for the sequential binary64 divider.
package fp64_pkg;

   localparam int          FP64_BIAS    = 1023;
   localparam logic [10:0] FP64_EXP_MAX = 11'h7FF;
   localparam logic [63:0] FP64_QNAN    = 64'h7FF8000000000001;
   localparam int          QBITS        = 55;

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

endpackage

// File: rtl/fp64_classify.sv
// Unpacks a binary64 operand and flags NaN / infinity / zero (subnormals flush to zero).
module fp64_classify
   import fp64_pkg::*;
(
   input  logic [63:0] x,
   output logic        sign,
   output logic [10:0] exp,
   output logic [52:0] mant,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero
);

   logic frac_nz;

   assign sign    = x[63];
   assign exp     = x[62:52];
   assign frac_nz = |x[51:0];
   assign mant    = {(exp != 11'd0), x[51:0]};
   assign is_nan  = (exp == FP64_EXP_MAX) && frac_nz;
   assign is_inf  = (exp == FP64_EXP_MAX) && !frac_nz;
   assign is_zero = (exp == 11'd0);

endmodule

// File: rtl/fp64_div_seq.sv
// Sequential binary64 divider: radix-2 restoring division, one quotient bit per cycle, RNE rounding.
module fp64_div_seq
   import fp64_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] a,
   input  logic [63:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result
);

   logic        sa, sb, a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic [10:0] ea, eb;
   logic [52:0] ma, mb;

   fp64_classify u_cls_a (.x(a), .sign(sa), .exp(ea), .mant(ma),
                          .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero));
   fp64_classify u_cls_b (.x(b), .sign(sb), .exp(eb), .mant(mb),
                          .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero));

   state_t             state;
   logic [5:0]         cnt;
   logic [53:0]        rem;
   logic [52:0]        div;
   logic [QBITS-1:0]   q;
   logic signed [12:0] e;
   logic               sign;

   // Operand setup and special-case result
   logic               sq, special, mant_lt;
   logic [63:0]        special_res;
   logic [53:0]        rem_init;
   logic signed [12:0] e_init;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sq          = sa ^ sb;
      special     = 1'b1;
      special_res = {sq, 63'd0};
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
         special_res = FP64_QNAN;
      else if (a_inf || b_zero)
         special_res = {sq, FP64_EXP_MAX, 52'd0};
      else if (a_zero || b_inf)
         special_res = {sq, 63'd0};
      else
         special = 1'b0;

      // Pre-normalize so the first quotient bit is always the integer 1
      mant_lt  = (ma < mb);
      rem_init = mant_lt ? {ma, 1'b0} : {1'b0, ma};
      e_init   = 13'(ea) - 13'(eb) + 13'(FP64_BIAS) - 13'(mant_lt);
   end

   // One shared subtract/shift step of the restoring divider
   logic        q_bit;
   logic [53:0] rem_sel, rem_next;

   always_comb begin
      q_bit    = (rem >= {1'b0, div});
      rem_sel  = q_bit ? (rem - {1'b0, div}) : rem;
      rem_next = {rem_sel[52:0], 1'b0};
   end

   // Round-to-nearest-even and range limiting
   logic [53:0]        mant_r;
   logic               round_up, carry;
   logic signed [12:0] e_r;
   logic [51:0]        frac;
   logic [63:0]        rnd_result;

   always_comb begin
      round_up = q[1] && (q[0] || (|rem) || q[2]);
      mant_r   = {1'b0, q[54:2]} + 54'(round_up);
      carry    = mant_r[53];
      e_r      = carry ? e + 13'sd1 : e;
      frac     = carry ? mant_r[52:1] : mant_r[51:0];
      if (e_r >= 13'sd2047)
         rnd_result = {sign, FP64_EXP_MAX, 52'd0};
      else if (e_r <= 13'sd0)
         rnd_result = {sign, 63'd0};
      else
         rnd_result = {sign, e_r[10:0], frac};
   end

   always_ff @(posedge clk) begin
      // NOTE: only control state is reset; datapath registers are always loaded before being read.
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= 64'd0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               in_ready <= 1'b0;
               sign     <= sq;
               if (special) begin
                  result    <= special_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rem   <= rem_init;
                  div   <= mb;
                  q     <= '0;
                  cnt   <= '0;
                  e     <= e_init;
                  state <= DIV;
               end
            end
            DIV: begin
               rem <= rem_next;
               q   <= {q[QBITS-2:0], q_bit};
               cnt <= cnt + 6'd1;
               if (cnt == 6'(QBITS - 1))
                  state <= ROUND;
            end
            ROUND: begin
               result    <= rnd_result;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
